// File: rtl/bitty_pkg.sv
// -----------------------------------------------------------------------------
// bitty_pkg
// Shared definitions for the bitty core fetch path.
//   - Default address and instruction widths.
//   - fetch_state_t: fetch sequencer states.
//   - npc_sel_t: selector for the shared next-pc unit.
//   - HALT opcode constant and a decode helper used by the core.
// -----------------------------------------------------------------------------
package bitty_pkg;

    localparam int BITTY_ADDR_W  = 8;
    localparam int BITTY_INSTR_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

    typedef enum logic [1:0] {
        NPC_HOLD   = 2'd0,
        NPC_INC    = 2'd1,
        NPC_BRANCH = 2'd2
    } npc_sel_t;

    // Top nibble of a 16-bit instruction is the opcode; 4'hF stops the core.
    localparam logic [3:0] OP_HALT = 4'hF;

    function automatic logic is_halt_instr(input logic [BITTY_INSTR_W-1:0] word);
        return word[BITTY_INSTR_W-1 -: 4] == OP_HALT;
    endfunction

endpackage

// File: rtl/bitty_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// bitty_fetch_ctrl_if
// Read port of the synchronous instruction memory (one-cycle read latency).
//   mem_rd_en  : read enable (driven by the fetch controller)
//   mem_addr   : read address (driven by the fetch controller)
//   mem_rdata  : read data, valid the cycle after mem_rd_en (driven by memory)
// Modports: master = fetch controller, slave = instruction memory.
// -----------------------------------------------------------------------------
interface bitty_fetch_ctrl_if
    import bitty_pkg::*;
#(
    parameter int ADDR_W  = BITTY_ADDR_W,
    parameter int INSTR_W = BITTY_INSTR_W
);

    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata
    );

endinterface

// File: rtl/bitty_fetch_ctrl_next_pc.sv
// -----------------------------------------------------------------------------
// bitty_next_pc
// Combinational next-pc select shared by the fetch sequencer and the core's
// branch unit.
//   pc            : current program counter
//   branch_target : taken-branch destination (used verbatim)
//   sel           : NPC_HOLD / NPC_INC / NPC_BRANCH
//   next_pc       : selected next program counter
// pc+1 wraps modulo 2**ADDR_W because the sum is truncated to ADDR_W bits.
// -----------------------------------------------------------------------------
module bitty_next_pc
    import bitty_pkg::*;
#(
    parameter int ADDR_W = BITTY_ADDR_W
)
(
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] branch_target,
    input  npc_sel_t          sel,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc;
        case (sel)
            NPC_INC:    next_pc = pc + 1'b1;
            NPC_BRANCH: next_pc = branch_target;
            default:    next_pc = pc;
        endcase
    end

endmodule

// File: rtl/bitty_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// bitty_fetch_ctrl
// Instruction-fetch sequencer for the bitty core. Owns the program counter,
// drives the instruction-memory read port and presents one registered
// instruction at a time to the execute stage.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   start          : pulse, leaves IDLE and fetches at the current pc
//   done           : core retired the current instruction (EXEC only)
//   branch_en      : with done, go to branch_target instead of pc+1
//   branch_target  : next pc for a taken branch
//   halt_req       : with done, stop after the current instruction
//   mem            : instruction-memory read port (master side)
//   pc             : address of the instruction held in instr
//   instr          : registered instruction
//   instr_valid    : instr holds a fetched, unretired instruction
//   halted         : high in HALT
//
// Build option: BITTY_FETCH_PREFETCH_EN
//   When defined, the word at pc+1 is read speculatively on the first EXEC
//   cycle of each instruction and held in a one-entry buffer, so a sequential
//   done can present the next instruction one cycle later without FETCH/LATCH.
// -----------------------------------------------------------------------------
module bitty_fetch_ctrl
    import bitty_pkg::*;
#(
    parameter int                ADDR_W   = BITTY_ADDR_W,
    parameter int                INSTR_W  = BITTY_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                done,
    input  logic                branch_en,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic                halt_req,
    bitty_fetch_ctrl_if.master  mem,
    output logic [ADDR_W-1:0]   pc,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    output logic                halted
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_FETCH = FETCH;
    localparam logic [2:0] S_LATCH = LATCH;
    localparam logic [2:0] S_EXEC  = EXEC;
    localparam logic [2:0] S_HALT  = HALT;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    npc_sel_t          npc_sel;
    logic [ADDR_W-1:0] pc_nxt;

    // pc only moves when done is accepted in EXEC; every other state selects
    // NPC_HOLD, so pc can be loaded from pc_nxt unconditionally.
    bitty_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc            (pc),
        .branch_target (branch_target),
        .sel           (npc_sel),
        .next_pc       (pc_nxt)
    );

`ifdef BITTY_FETCH_PREFETCH_EN
    logic               first_exec;  // first cycle in EXEC for the current instr
    logic               pf_rd;       // speculative read of pc+1 this cycle
    logic               pf_pending;  // speculative read data arrives this cycle
    logic               pf_valid;    // pf_buf holds the word at pc+1
    logic [INSTR_W-1:0] pf_buf;
    logic               pf_hit;      // sequential done served from pf_buf
    logic [ADDR_W-1:0]  pf_addr;

    bitty_next_pc #(.ADDR_W(ADDR_W)) u_pf_addr (
        .pc            (pc),
        .branch_target (branch_target),
        .sel           (NPC_INC),
        .next_pc       (pf_addr)
    );

    assign pf_rd = (state == S_EXEC) && first_exec;
`endif

    // ---- next-state / next-pc decode ----
    always_comb begin
        state_nxt = state;
        npc_sel   = NPC_HOLD;
`ifdef BITTY_FETCH_PREFETCH_EN
        pf_hit    = 1'b0;
`endif
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_EXEC;
            S_EXEC: begin
                if (done) begin
                    // halt_req outranks branch_en; pc is left untouched on halt.
                    if (halt_req) begin
                        state_nxt = S_HALT;
                    end else begin
                        npc_sel   = branch_en ? NPC_BRANCH : NPC_INC;
                        state_nxt = S_FETCH;
`ifdef BITTY_FETCH_PREFETCH_EN
                        if (!branch_en && pf_valid) begin
                            pf_hit    = 1'b1;
                            state_nxt = S_EXEC;
                        end
`endif
                    end
                end
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---- memory read port ----
    always_comb begin
        mem.mem_rd_en = (state == S_FETCH);
        mem.mem_addr  = pc;
`ifdef BITTY_FETCH_PREFETCH_EN
        if (pf_rd) begin
            mem.mem_rd_en = 1'b1;
            mem.mem_addr  = pf_addr;
        end
`endif
    end

    assign halted = (state == S_HALT);

    // ---- state, pc and instruction registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            case (state)
                S_LATCH: begin
                    instr       <= mem.mem_rdata;
                    instr_valid <= 1'b1;
                end
                S_EXEC: begin
                    if (done) begin
                        instr_valid <= 1'b0;
`ifdef BITTY_FETCH_PREFETCH_EN
                        if (pf_hit) begin
                            instr       <= pf_buf;
                            instr_valid <= 1'b1;
                        end
`endif
                    end
                end
                S_HALT:  instr_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef BITTY_FETCH_PREFETCH_EN
    // ---- prefetch buffer ----
    // A speculative read is only kept if the instruction it was issued for is
    // still in EXEC when the data returns; any accepted done empties the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_exec <= 1'b0;
            pf_pending <= 1'b0;
            pf_valid   <= 1'b0;
        end else begin
            first_exec <= (state == S_LATCH) || pf_hit;
            pf_pending <= pf_rd && !done;
            if ((state == S_EXEC) && done) begin
                pf_valid <= 1'b0;
            end else if (pf_pending) begin
                pf_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pf_pending) begin
            pf_buf <= mem.mem_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_bitty_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bitty_fetch_ctrl
// Self-checking bench for bitty_fetch_ctrl. A behavioural memory and an
// address-level reference model (expected pc / instruction / latency) are kept
// here; directed scenarios are followed by a randomized instruction stream.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bitty_fetch_ctrl;
    import bitty_pkg::*;

    localparam int              AW     = 8;
    localparam int              IW     = 16;
    localparam logic [AW-1:0]   RST_PC = '0;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          done;
    logic          branch_en;
    logic [AW-1:0] branch_target;
    logic          halt_req;
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          halted;

    int n_checks = 0;
    int n_errors = 0;

    logic [IW-1:0] mem [256];
    logic [AW-1:0] exp_pc;

    bitty_fetch_ctrl_if #(.ADDR_W(AW), .INSTR_W(IW)) mif ();

    bitty_fetch_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .done          (done),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .mem           (mif),
        .pc            (pc),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) begin
        if (mif.mem_rd_en) mif.mem_rdata <= mem[mif.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for instr_valid after a start pulse driven at the current negedge.
    task automatic wait_first_valid();
        int n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (!instr_valid && mif.mem_rd_en) chk("start_fetch_addr", mif.mem_addr, exp_pc);
        end while (!instr_valid && n < 20);
        chk("start_latency", n, 3);
        chk("start_pc", pc, exp_pc);
        chk("start_instr", instr, mem[exp_pc]);
    endtask

    // Called at the negedge of the first EXEC cycle of an instruction: holds it
    // for w cycles, retires it with done (optionally branching) and checks the
    // next instruction against the model.
    task automatic exec_one(input logic br, input logic [AW-1:0] tgt, input int w);
        int            n;
        int            exp_lat;
        logic [AW-1:0] nxt;
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            chk("hold_valid", instr_valid, 1'b1);
        end
        nxt     = br ? tgt : AW'(exp_pc + 1);
        exp_lat = 3;
`ifdef BITTY_FETCH_PREFETCH_EN
        // The buffer is full from the third EXEC cycle onward.
        if (!br && w >= 2) exp_lat = 1;
`endif
        done          = 1'b1;
        branch_en     = br;
        branch_target = tgt;
        n = 0;
        do begin
            @(negedge clk);
            done      = 1'b0;
            branch_en = 1'b0;
            n++;
            if (!instr_valid && mif.mem_rd_en) chk("fetch_addr", mif.mem_addr, nxt);
        end while (!instr_valid && n < 20);
        chk("latency", n, exp_lat);
        exp_pc = nxt;
        chk("pc", pc, exp_pc);
        chk("instr", instr, mem[exp_pc]);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[3] = 16'h4444;

        reset = 1'b1; start = 1'b0; done = 1'b0; branch_en = 1'b0;
        branch_target = '0; halt_req = 1'b0;
        exp_pc = RST_PC;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_rd_en", mif.mem_rd_en, 0);
        chk("rst_addr", mif.mem_addr, RST_PC);
        reset = 1'b0;

        // Spurious done in IDLE must not move pc or leave IDLE.
        @(negedge clk);
        done = 1'b1; branch_en = 1'b1; branch_target = 8'h55;
        @(negedge clk);
        done = 1'b0; branch_en = 1'b0;
        chk("idle_done_pc", pc, RST_PC);
        chk("idle_done_rd", mif.mem_rd_en, 0);
        @(negedge clk);
        chk("idle_done_valid", instr_valid, 0);

        // Start, with a spurious done during LATCH.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("fetch_rd_en", mif.mem_rd_en, 1);
        chk("fetch_addr0", mif.mem_addr, RST_PC);
        @(negedge clk);
        done = 1'b1; branch_en = 1'b1; branch_target = 8'h33;
        @(negedge clk);
        done = 1'b0; branch_en = 1'b0;
        chk("first_valid", instr_valid, 1);
        chk("first_pc", pc, 0);
        chk("first_instr", instr, 16'h1111);

        // Sequential fetch 1..3.
        for (int i = 0; i < 3; i++) exec_one(1'b0, '0, i);

        // Branch back to 2, then branch at pc=2 to 0x80.
        exec_one(1'b1, 8'h02, 1);
        exec_one(1'b1, 8'h80, 0);

        // Wrap: branch to 0xFF then step sequentially to 0x00.
        exec_one(1'b1, 8'hFF, 2);
        exec_one(1'b0, '0, 3);

        // Randomized instruction stream.
        for (int i = 0; i < 40; i++) begin
            exec_one($urandom_range(0, 3) == 0, AW'($urandom), $urandom_range(0, 3));
        end

        // Reset during LATCH aborts the fetch; first make pc non-zero.
        exec_one(1'b1, 8'h21, 0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_valid", instr_valid, 0);
        chk("abort_pc", pc, RST_PC);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_idle_rd", mif.mem_rd_en, 0);
            chk("abort_idle_valid", instr_valid, 0);
        end
        exp_pc = RST_PC;

        // Restart, go to pc=5, halt with branch_en also set.
        start = 1'b1;
        wait_first_valid();
        exec_one(1'b1, 8'h05, 1);
        done = 1'b1; halt_req = 1'b1; branch_en = 1'b1; branch_target = 8'h40;
        @(negedge clk);
        done = 1'b0; halt_req = 1'b0; branch_en = 1'b0;
        chk("halt_halted", halted, 1);
        chk("halt_valid", instr_valid, 0);
        chk("halt_pc", pc, 8'h05);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("halt_rd_en", mif.mem_rd_en, 0);
            chk("halt_stays", halted, 1);
            chk("halt_pc_hold", pc, 8'h05);
            start = (i == 1);
            done  = (i == 3);
        end
        start = 1'b0; done = 1'b0;

        // Reset leaves HALT.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("post_halt_pc", pc, RST_PC);
        chk("post_halt_halted", halted, 0);
        chk("post_halt_valid", instr_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global guard so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
